// File: rtl/vswap_pkg.sv
// Shared constants and the queue entry layout for the vector-swap issue path.
package vswap_pkg;

  localparam int ELEMENT_SIZE = 8;
  localparam int VECTOR_SIZE  = 8;
  localparam int DIR_W        = 3;

  typedef struct packed {
    logic [ELEMENT_SIZE*VECTOR_SIZE-1:0] vec;
    logic [DIR_W-1:0]                    dir1;
    logic [DIR_W-1:0]                    dir2;
  } vswap_entry_t;

endpackage

// File: rtl/vswap_fifo.sv
// Entry storage for the issue queue: power-of-two ring buffer with
// wrapping read/write pointers and an occupancy count.
module vswap_fifo
  import vswap_pkg::*;
#(
  parameter int WIDTH = 70,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      count_q, count_d;

  // Next-state for pointers and count; pointers wrap because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_i) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/vswap_issue_queue.sv
// Issue queue in front of the vector swapper: buffers operations and loads
// the swapper's operand registers. Optional issue counter: VSWAP_ISSUE_STATS_EN.
module vswap_issue_queue #(
  parameter int ELEMENT_SIZE = vswap_pkg::ELEMENT_SIZE,
  parameter int VECTOR_SIZE  = vswap_pkg::VECTOR_SIZE,
  parameter int DEPTH        = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ELEMENT_SIZE*VECTOR_SIZE-1:0] in_vec,
  input  logic [vswap_pkg::DIR_W-1:0]         in_dir1,
  input  logic [vswap_pkg::DIR_W-1:0]         in_dir2,
  input  logic                                out_stall,
  output logic [ELEMENT_SIZE*VECTOR_SIZE-1:0] out_vec,
  output logic [vswap_pkg::DIR_W-1:0]         out_dir1,
  output logic [vswap_pkg::DIR_W-1:0]         out_dir2,
  output logic                                out_issue,
  output logic                                res_valid,
`ifdef VSWAP_ISSUE_STATS_EN
  output logic [15:0]                         issue_cnt,
`endif
  output logic [$clog2(DEPTH):0]              occupancy
);

  import vswap_pkg::*;

  localparam int VW = ELEMENT_SIZE*VECTOR_SIZE;
  localparam int EW = VW + 2*DIR_W;

  logic          push_s, pop_s, full_s, empty_s;
  logic [EW-1:0] head_s;

  logic [VW-1:0]    out_vec_q, out_vec_d;
  logic [DIR_W-1:0] out_dir1_q, out_dir1_d;
  logic [DIR_W-1:0] out_dir2_q, out_dir2_d;
  logic             out_issue_q, res_valid_q;

  vswap_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({in_vec, in_dir1, in_dir2}),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (occupancy)
  );

  assign in_ready = ~full_s;
  assign push_s   = in_valid & ~full_s;
  assign pop_s    = ~empty_s & ~out_stall;

  // Operands hold between issues: the swapper re-samples them every falling edge.
  always_comb begin
    out_vec_d  = out_vec_q;
    out_dir1_d = out_dir1_q;
    out_dir2_d = out_dir2_q;
    if (pop_s) begin
      {out_vec_d, out_dir1_d, out_dir2_d} = head_s;
    end else begin
      out_vec_d  = out_vec_q;
      out_dir1_d = out_dir1_q;
      out_dir2_d = out_dir2_q;
    end
  end

  // Issue registers and the one-cycle-delayed result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vec_q   <= '0;
      out_dir1_q  <= '0;
      out_dir2_q  <= '0;
      out_issue_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      out_vec_q   <= out_vec_d;
      out_dir1_q  <= out_dir1_d;
      out_dir2_q  <= out_dir2_d;
      out_issue_q <= pop_s;
      res_valid_q <= out_issue_q;
    end
  end

  assign out_vec   = out_vec_q;
  assign out_dir1  = out_dir1_q;
  assign out_dir2  = out_dir2_q;
  assign out_issue = out_issue_q;
  assign res_valid = res_valid_q;

`ifdef VSWAP_ISSUE_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;

  // Saturating count of issue pulses.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    if (out_issue_q && (issue_cnt_q != 16'hFFFF)) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end else begin
      issue_cnt_d = issue_cnt_q;
    end
  end

  // Statistics register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= 16'h0000;
    end else begin
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_vswap_issue_queue.sv
// Scoreboard bench for vswap_issue_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares on every out_issue pulse.
module tb_vswap_issue_queue;
  import vswap_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_vec;
  logic [2:0]  in_dir1, in_dir2;
  logic        out_stall;
  logic [63:0] out_vec;
  logic [2:0]  out_dir1, out_dir2;
  logic        out_issue;
  logic        res_valid;
  logic [2:0]  occupancy;
`ifdef VSWAP_ISSUE_STATS_EN
  logic [15:0] issue_cnt;
  int          e_cnt = 0;
`endif

  int checks   = 0;
  int failures = 0;

  vswap_entry_t exp_q[$];
  int   occ     = 0;
  logic e_issue = 1'b0;
  logic e_res   = 1'b0;

  vswap_issue_queue #(.ELEMENT_SIZE(8), .VECTOR_SIZE(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_dir1   (in_dir1),
    .in_dir2   (in_dir2),
    .out_stall (out_stall),
    .out_vec   (out_vec),
    .out_dir1  (out_dir1),
    .out_dir2  (out_dir2),
    .out_issue (out_issue),
    .res_valid (res_valid),
`ifdef VSWAP_ISSUE_STATS_EN
    .issue_cnt (issue_cnt),
`endif
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every issue must match the oldest accepted, not-yet-issued entry.
  always @(negedge clk) begin : monitor
    vswap_entry_t e;
    if (rst_n === 1'b1 && out_issue === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("issue_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_vec", out_vec, e.vec);
        chk("out_dir1", {61'd0, out_dir1}, {61'd0, e.dir1});
        chk("out_dir2", {61'd0, out_dir2}, {61'd0, e.dir2});
      end
    end
  end

  // One clock cycle: drive at posedge+1, check at negedge, update model after the edge.
  task automatic step(input logic v, input logic [63:0] vec, input logic [2:0] d1,
                      input logic [2:0] d2, input logic st);
    logic push, pop;
    vswap_entry_t e;
    in_valid = v; in_vec = vec; in_dir1 = d1; in_dir2 = d2; out_stall = st;
    @(negedge clk);
    chk("in_ready", {63'd0, in_ready}, {63'd0, (occ != DEPTH)});
    chk("occupancy", {61'd0, occupancy}, 64'(occ));
    chk("out_issue_timing", {63'd0, out_issue}, {63'd0, e_issue});
    chk("res_valid_timing", {63'd0, res_valid}, {63'd0, e_res});
`ifdef VSWAP_ISSUE_STATS_EN
    chk("issue_cnt", {48'd0, issue_cnt}, 64'(e_cnt));
`endif
    push = v && (occ != DEPTH);
    pop  = (occ > 0) && !st;
    if (push) begin
      e.vec = vec; e.dir1 = d1; e.dir2 = d2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
`ifdef VSWAP_ISSUE_STATS_EN
    if (e_issue && e_cnt != 65535) e_cnt++;
`endif
    e_res   = e_issue;
    e_issue = pop;
    occ     = occ + (push ? 1 : 0) - (pop ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 3'd6, 3'd1, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_occupancy"}, {61'd0, occupancy}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_out_vec"}, out_vec, 64'd0);
    chk({tag, "_out_dirs"}, {58'd0, out_dir1, out_dir2}, 64'd0);
    chk({tag, "_out_issue"}, {63'd0, out_issue}, 64'd0);
    chk({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_vec = 64'd0; in_dir1 = 3'd0; in_dir2 = 3'd0; out_stall = 1'b0;
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    in_valid = 1'b1; in_vec = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk_reset_outputs("reset_held");
    rst_n = 1'b1;

    // Basic issue: push at edge 1, issue after edge 2, res_valid after edge 3.
    step(1'b1, 64'h0706050403020100, 3'd0, 3'd7, 1'b0);
    idle(3);

    // Fill under stall, reject a 5th push, then a full+pop cycle still rejects the push.
    step(1'b1, 64'hA0A1A2A3A4A5A6A7, 3'd1, 3'd2, 1'b1);
    step(1'b1, 64'hB0B1B2B3B4B5B6B7, 3'd3, 3'd3, 1'b1);
    step(1'b1, 64'hC0C1C2C3C4C5C6C7, 3'd4, 3'd5, 1'b1);
    step(1'b1, 64'hD0D1D2D3D4D5D6D7, 3'd6, 3'd1, 1'b1);
    step(1'b1, 64'hE0E1E2E3E4E5E6E7, 3'd2, 3'd2, 1'b1);
    step(1'b1, 64'hE8E9EAEBECEDEEEF, 3'd7, 3'd0, 1'b0);
    idle(6);

    // Occupancy 2, then six simultaneous push/pop cycles wrap the pointers.
    step(1'b1, 64'h1111_0000_0000_0001, 3'd0, 3'd1, 1'b1);
    step(1'b1, 64'h1111_0000_0000_0002, 3'd1, 3'd2, 1'b1);
    for (int i = 0; i < 6; i++)
      step(1'b1, 64'h2222_0000_0000_0000 | 64'(i), 3'(i), 3'(7 - i), 1'b0);
    idle(4);

    // Reset with three entries queued and an issue pulse outstanding.
    step(1'b1, 64'h3333_0000_0000_0001, 3'd1, 3'd1, 1'b1);
    step(1'b1, 64'h3333_0000_0000_0002, 3'd2, 3'd2, 1'b1);
    step(1'b1, 64'h3333_0000_0000_0003, 3'd3, 3'd3, 1'b1);
    step(1'b1, 64'h3333_0000_0000_0004, 3'd4, 3'd4, 1'b1);
    step(1'b0, 64'h0, 3'd0, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    occ = 0; e_issue = 1'b0; e_res = 1'b0;
`ifdef VSWAP_ISSUE_STATS_EN
    e_cnt = 0;
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    // Queue still works after reset.
    step(1'b1, 64'h4444_5555_6666_7777, 3'd5, 3'd5, 1'b0);
    idle(3);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
